// File: rtl/axi_lite_read_arbiter_if.sv
// rtl/axi_lite_read_arbiter_if.sv - requester, AXI-Lite read and status signals of the read arbiter
interface axi_lite_read_arbiter_if #(
  parameter int NUM_REQ    = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [NUM_REQ-1:0]            rsp_ready_i;
  logic [ADDR_WIDTH-1:0]         ar_addr_o;
  logic                          ar_valid_o;
  logic                          ar_ready_i;
  logic [DATA_WIDTH-1:0]         r_data_i;
  logic [1:0]                    r_resp_i;
  logic                          r_valid_i;
  logic                          r_ready_o;
  logic                          outst_full_o;
  logic                          idle_o;
  logic                          err_o;

  // arbiter side
  modport master (
    input  req_addr_i, req_valid_i, rsp_ready_i, ar_ready_i, r_data_i, r_resp_i, r_valid_i,
    output req_ready_o, rsp_data_o, rsp_valid_o, ar_addr_o, ar_valid_o, r_ready_o,
           outst_full_o, idle_o, err_o
  );

  // requesters plus AXI-Lite slave side
  modport slave (
    output req_addr_i, req_valid_i, rsp_ready_i, ar_ready_i, r_data_i, r_resp_i, r_valid_i,
    input  req_ready_o, rsp_data_o, rsp_valid_o, ar_addr_o, ar_valid_o, r_ready_o,
           outst_full_o, idle_o, err_o
  );
endinterface

// File: rtl/axi_lite_read_arbiter.sv
// rtl/axi_lite_read_arbiter.sv - round-robin sharing of one AXI-Lite read channel with in-order R routing
module axi_lite_read_arbiter #(
  parameter int NUM_REQ    = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input logic                      clk_i,
  input logic                      rst_i,
  axi_lite_read_arbiter_if.master  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTST);

  // AR holding register and arbitration state
  logic                  ar_valid_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [IDX_W-1:0]      rr_ptr_q;

  // Order FIFO: requester index per read, oldest at rd_ptr_q.
  // Occupancy equals count_q, so no separate fill level is kept.
  logic [IDX_W-1:0]      order_q [MAX_OUTST];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  err_q;

  logic                  slot_free;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W:0]        cand;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  accept;
  logic [NUM_REQ-1:0]    grant;
  logic                  fifo_empty;
  logic [IDX_W-1:0]      head;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  r_ready;
  logic                  pop;

  assign slot_free  = !ar_valid_q || bus.ar_ready_i;
  assign accept     = slot_free && (count_q < MAX_CNT) && win_found;
  assign fifo_empty = (count_q == '0);
  assign head       = order_q[rd_ptr_q];
  assign pop        = bus.r_valid_i && r_ready && !fifo_empty;

  // Find the first valid requester scanning upward from rr_ptr, wrapping at NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!win_found && bus.req_valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Select the winner's address and form the one-hot ready
  always_comb begin
    win_addr = '0;
    grant    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_addr = bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        grant[k] = accept;
      end
    end
  end

  // Route the R beat to the oldest outstanding requester; drain stray beats
  always_comb begin
    rsp_valid = '0;
    r_ready   = 1'b1;
    if (!fifo_empty) begin
      r_ready = bus.rsp_ready_i[head];
      for (int k = 0; k < NUM_REQ; k++) begin
        rsp_valid[k] = bus.r_valid_i && (head == IDX_W'(k));
      end
    end
  end

  // AR register, round-robin pointer, FIFO pointers, in-flight count and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= win_addr;
        rr_ptr_q   <= (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      end else if (bus.ar_ready_i) begin
        ar_valid_q <= 1'b0;
      end

      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if ((bus.r_valid_i && r_ready && (bus.r_resp_i != 2'b00)) ||
          (bus.r_valid_i && fifo_empty)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Order FIFO storage; stale entries are unreachable after reset, so no clear
  always_ff @(posedge clk_i) begin
    if (accept) begin
      order_q[wr_ptr_q] <= win_idx;
    end
  end

  assign bus.req_ready_o  = grant;
  assign bus.rsp_data_o   = bus.r_data_i;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.r_ready_o    = r_ready;
  assign bus.ar_addr_o    = ar_addr_q;
  assign bus.ar_valid_o   = ar_valid_q;
  assign bus.outst_full_o = (count_q == MAX_CNT);
  assign bus.idle_o       = fifo_empty;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// tb/tb_axi_lite_read_arbiter.sv - scoreboard bench for axi_lite_read_arbiter
module tb_axi_lite_read_arbiter;

  localparam int NR = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_read_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state and scoreboards
  logic           m_arv = 1'b0;
  int             m_rr  = 0;
  int             m_cnt = 0;
  logic           m_err = 1'b0;
  int             exp_order[$];
  logic [AW-1:0]  exp_ar[$];
  logic           m_acc;
  logic           m_pop;
  logic           m_err_set;
  int             m_w;
  int             m_c;
  int             m_own;
  logic [NR-1:0]  e_grant;
  logic [NR-1:0]  e_rsp;

  // Lockstep reference: check every output each cycle, update model from sampled inputs
  always @(negedge clk) begin
    m_acc = 1'b0;
    m_w   = 0;
    if ((!m_arv || bus.ar_ready_i) && m_cnt < MO) begin
      for (int i = 0; i < NR; i++) begin
        m_c = (m_rr + i) % NR;
        if (!m_acc && bus.req_valid_i[m_c]) begin
          m_acc = 1'b1;
          m_w   = m_c;
        end
      end
    end
    e_grant = m_acc ? (NR'(1) << m_w) : '0;
    if (mon_en) begin
      check("mon_grant", 64'(bus.req_ready_o), 64'(e_grant));
      check("mon_ar_valid", 64'(bus.ar_valid_o), 64'(m_arv));
      check("mon_idle", 64'(bus.idle_o), 64'(m_cnt == 0));
      check("mon_full", 64'(bus.outst_full_o), 64'(m_cnt == MO));
      check("mon_err", 64'(bus.err_o), 64'(m_err));
    end

    if (m_arv && bus.ar_ready_i && exp_ar.size() > 0) begin
      if (mon_en) check("mon_ar_addr", 64'(bus.ar_addr_o), 64'(exp_ar[0]));
      void'(exp_ar.pop_front());
    end

    m_pop     = 1'b0;
    m_err_set = 1'b0;
    if (exp_order.size() == 0) begin
      if (mon_en) begin
        check("mon_rsp_valid_empty", 64'(bus.rsp_valid_o), 64'h0);
        check("mon_r_ready_empty", 64'(bus.r_ready_o), 64'h1);
      end
      if (bus.r_valid_i) m_err_set = 1'b1;
    end else begin
      m_own = exp_order[0];
      e_rsp = bus.r_valid_i ? (NR'(1) << m_own) : '0;
      if (mon_en) begin
        check("mon_rsp_valid", 64'(bus.rsp_valid_o), 64'(e_rsp));
        check("mon_r_ready", 64'(bus.r_ready_o), 64'(bus.rsp_ready_i[m_own]));
        if (bus.r_valid_i) check("mon_rsp_data", 64'(bus.rsp_data_o), 64'(bus.r_data_i));
      end
      if (bus.r_valid_i && bus.rsp_ready_i[m_own]) begin
        m_pop = 1'b1;
        void'(exp_order.pop_front());
        if (bus.r_resp_i != 2'b00) m_err_set = 1'b1;
      end
    end

    if (m_acc) begin
      exp_order.push_back(m_w);
      exp_ar.push_back(bus.req_addr_i[m_w*AW +: AW]);
    end

    if (rst) begin
      m_arv = 1'b0;
      m_rr  = 0;
      m_cnt = 0;
      m_err = 1'b0;
      exp_order.delete();
      exp_ar.delete();
    end else begin
      if (m_acc) begin
        m_arv = 1'b1;
        m_rr  = (m_w + 1) % NR;
      end else if (bus.ar_ready_i) begin
        m_arv = 1'b0;
      end
      m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
      if (m_err_set) m_err = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] regrant [4] = '{5'b00000, 5'b10000, 5'b00001, 5'b00010};
  logic [NR-1:0] drain3  [3] = '{5'b10000, 5'b00001, 5'b00010};
  logic [NR-1:0] drain4  [4] = '{5'b01000, 5'b10000, 5'b00001, 5'b00010};

  initial begin
    bus.req_addr_i  = '0;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    bus.ar_ready_i  = 1'b0;
    bus.r_data_i    = '0;
    bus.r_resp_i    = 2'b00;
    bus.r_valid_i   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    check("rst_full", 64'(bus.outst_full_o), 64'h0);
    check("rst_idle", 64'(bus.idle_o), 64'h1);
    check("rst_ar_valid", 64'(bus.ar_valid_o), 64'h0);
    check("rst_ar_addr", 64'(bus.ar_addr_o), 64'h0);
    check("rst_err", 64'(bus.err_o), 64'h0);
    tick();

    // round-robin until outstanding limit, then refill behind returning beats
    for (int k = 0; k < NR; k++) bus.req_addr_i[k*AW +: AW] = 32'h1000_0000 + 32'(k * 16);
    bus.req_valid_i = 5'b11111;
    bus.ar_ready_i  = 1'b1;
    bus.rsp_ready_i = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arb_grant", 64'(bus.req_ready_o), 64'h1 << i);
      tick();
    end
    @(negedge clk);
    check("arb_full_nogrant", 64'(bus.req_ready_o), 64'h0);
    check("arb_full", 64'(bus.outst_full_o), 64'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      check("arb_rsp_owner", 64'(bus.rsp_valid_o), 64'h1 << i);
      check("arb_regrant", 64'(bus.req_ready_o), 64'(regrant[i]));
      tick();
    end
    bus.req_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      bus.r_data_i = 32'hB000_0000 + 32'(i);
      @(negedge clk);
      check("arb_drain_owner", 64'(bus.rsp_valid_o), 64'(drain3[i]));
      tick();
    end
    bus.r_valid_i = 1'b0;
    @(negedge clk);
    check("arb_idle", 64'(bus.idle_o), 64'h1);
    tick();

    // AR latency and address hold under ar_ready backpressure
    bus.req_addr_i[2*AW +: AW] = 32'h8000_0010;
    bus.ar_ready_i  = 1'b0;
    bus.req_valid_i = 5'b00100;
    @(negedge clk);
    check("lat_grant", 64'(bus.req_ready_o), 64'h4);
    tick();
    bus.req_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_ar_valid", 64'(bus.ar_valid_o), 64'h1);
      check("lat_ar_addr", 64'(bus.ar_addr_o), 64'h8000_0010);
      tick();
    end
    bus.ar_ready_i = 1'b1;
    @(negedge clk);
    check("lat_ar_hs", 64'(bus.ar_valid_o), 64'h1);
    tick();
    @(negedge clk);
    check("lat_ar_drop", 64'(bus.ar_valid_o), 64'h0);
    tick();
    bus.r_valid_i = 1'b1;
    bus.r_data_i  = 32'h0000_0C0D;
    @(negedge clk);
    check("lat_rsp_owner", 64'(bus.rsp_valid_o), 64'h4);
    tick();
    bus.r_valid_i = 1'b0;

    // R backpressure from requester 1
    bus.req_addr_i[1*AW +: AW] = 32'h0000_1234;
    bus.req_valid_i = 5'b00010;
    @(negedge clk);
    check("bp_grant", 64'(bus.req_ready_o), 64'h2);
    tick();
    bus.req_valid_i = '0;
    bus.r_valid_i   = 1'b1;
    bus.r_data_i    = 32'hDEAD_BEEF;
    bus.rsp_ready_i = 5'b11101;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_r_ready", 64'(bus.r_ready_o), 64'h0);
      check("bp_rsp_data", 64'(bus.rsp_data_o), 64'hDEAD_BEEF);
      check("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'h2);
      tick();
    end
    bus.rsp_ready_i = 5'b11111;
    @(negedge clk);
    check("bp_release", 64'(bus.r_ready_o), 64'h1);
    tick();
    bus.r_valid_i = 1'b0;
    @(negedge clk);
    check("bp_idle", 64'(bus.idle_o), 64'h1);
    tick();

    // accept gated by pre-pop count at the outstanding limit
    bus.req_valid_i = 5'b11111;
    repeat (4) tick();
    bus.r_valid_i = 1'b1;
    bus.r_data_i  = 32'hC000_0001;
    @(negedge clk);
    check("sim_full", 64'(bus.outst_full_o), 64'h1);
    check("sim_gated", 64'(bus.req_ready_o), 64'h0);
    check("sim_pop", 64'(bus.r_ready_o), 64'h1);
    check("sim_owner", 64'(bus.rsp_valid_o), 64'h4);
    tick();
    bus.r_valid_i = 1'b0;
    @(negedge clk);
    check("sim_next", 64'(bus.req_ready_o), 64'h2);
    tick();
    bus.req_valid_i = '0;
    @(negedge clk);
    check("sim_refull", 64'(bus.outst_full_o), 64'h1);
    tick();
    bus.r_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.r_data_i = 32'hC100_0000 + 32'(i);
      @(negedge clk);
      check("sim_drain_owner", 64'(bus.rsp_valid_o), 64'(drain4[i]));
      tick();
    end
    bus.r_valid_i = 1'b0;

    // error response still delivered, error sticks
    bus.req_valid_i = 5'b01000;
    @(negedge clk);
    check("err_grant", 64'(bus.req_ready_o), 64'h8);
    tick();
    bus.req_valid_i = '0;
    bus.r_valid_i   = 1'b1;
    bus.r_resp_i    = 2'b10;
    bus.r_data_i    = 32'h1234_5678;
    @(negedge clk);
    check("err_rsp_owner", 64'(bus.rsp_valid_o), 64'h8);
    check("err_rsp_data", 64'(bus.rsp_data_o), 64'h1234_5678);
    check("err_before", 64'(bus.err_o), 64'h0);
    tick();
    bus.r_valid_i = 1'b0;
    bus.r_resp_i  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_sticky", 64'(bus.err_o), 64'h1);
      tick();
    end

    // reset with reads in flight
    bus.req_valid_i = 5'b11111;
    repeat (3) tick();
    rst = 1'b1;
    bus.req_valid_i = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rmid_ar_valid", 64'(bus.ar_valid_o), 64'h0);
    check("rmid_idle", 64'(bus.idle_o), 64'h1);
    check("rmid_err", 64'(bus.err_o), 64'h0);
    check("rmid_full", 64'(bus.outst_full_o), 64'h0);
    tick();
    bus.req_valid_i = 5'b11111;
    @(negedge clk);
    check("rmid_rr_ptr", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.req_valid_i = '0;
    bus.r_valid_i   = 1'b1;
    bus.r_data_i    = 32'h0BAD_F00D;
    @(negedge clk);
    check("rmid_rsp_owner", 64'(bus.rsp_valid_o), 64'h1);
    tick();

    // stray beat with nothing outstanding
    bus.r_data_i = 32'h0000_55AA;
    @(negedge clk);
    check("stray_r_ready", 64'(bus.r_ready_o), 64'h1);
    check("stray_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    check("stray_err_before", 64'(bus.err_o), 64'h0);
    tick();
    bus.r_valid_i = 1'b0;
    @(negedge clk);
    check("stray_err", 64'(bus.err_o), 64'h1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_read_arbiter.md
Name: axi_lite_read_arbiter

Overview:
- Shares the single AXI-Lite read channel (AR/R) between NUM_REQ read requesters: the input-node streamers and the configuration loader.
- Arbitration is round-robin. The block records the grant order in an order FIFO and uses it to route each in-order R beat back to its requester.
- Sits between the streaming state machines and the AXI-Lite-to-AXI converter. It exports an outstanding-full flag for the control unit's stall counters.

Parameters:
NUM_REQ, 5, number of requesters (index NUM_REQ-1 = configuration loader)
ADDR_WIDTH, 32, read address width
DATA_WIDTH, 32, read data width
MAX_OUTST, 4, maximum reads in flight (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester read address, slice k = requester k
req_valid_i  in  NUM_REQ  read request valid
req_ready_o  out  NUM_REQ  request accepted (one-hot or zero)
rsp_data_o  out  DATA_WIDTH  read data, broadcast to all requesters
rsp_valid_o  out  NUM_REQ  response valid, one-hot to owning requester
rsp_ready_i  in  NUM_REQ  requester can take response
ar_addr_o  out  ADDR_WIDTH  AXI-Lite AR address
ar_valid_o  out  1  AR valid
ar_ready_i  in  1  AR ready
r_data_i  in  DATA_WIDTH  AXI-Lite R data
r_resp_i  in  2  AXI-Lite R response
r_valid_i  in  1  R valid
r_ready_o  out  1  R ready
outst_full_o  out  1  in-flight count == MAX_OUTST
idle_o  out  1  no AR pending and order FIFO empty
err_o  out  1  sticky: SLVERR/DECERR or unexpected R beat

Behaviour:
- Reset (rst_i high at clk edge):
  - ar_valid_o=0, ar_addr_o=0, rr_ptr=0, order FIFO emptied, count=0, err_o=0.
  - Outputs after reset: req_ready_o=0, rsp_valid_o=0, outst_full_o=0, idle_o=1.
  - Reset mid-transaction discards all state. Any R beat returned afterwards is treated as unexpected (see below), so the system must quiesce the bus before asserting rst_i.
- AR holding register:
  - Slot is free when ar_valid_o=0 or ar_ready_i=1 this cycle.
  - Once ar_valid_o=1, ar_addr_o stays stable until the ar_ready_i handshake.
- Accept condition (combinational, same cycle):
  - Requires slot free, count < MAX_OUTST, and at least one req_valid_i bit set.
  - Winner k = first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready_o[k]=1 for that cycle only. req_ready_o never depends on r_* or rsp_* signals.
- On accept at cycle T:
  - ar_addr_o <= slice k; ar_valid_o=1 from T+1.
  - k pushed to order FIFO; count+1.
  - rr_ptr <= (k+1) mod NUM_REQ.
- Without an accept: rr_ptr holds; ar_valid_o clears on handshake.
- Throughput: one accept per cycle sustained while ar_ready_i=1 and count < MAX_OUTST.
- count covers both the pending AR and reads awaiting R. Hence outst_full_o = (count==MAX_OUTST), and idle_o = (count==0).
- R routing, all combinational:
  - h = order FIFO head.
  - When FIFO non-empty: rsp_valid_o[h] = r_valid_i, rsp_data_o = r_data_i, r_ready_o = rsp_ready_i[h].
  - When FIFO empty: r_ready_o=1 (beat drained), rsp_valid_o=0.
  - The R beat is delivered even when r_resp_i!=0.
- Pop on r_valid_i & r_ready_o with FIFO non-empty: count-1.
- Simultaneous accept and pop: count unchanged. Push and pop both happen even when count==MAX_OUTST, because the accept is gated by the pre-pop count.
- err_o set by:
  - r_valid_i & r_ready_o & (r_resp_i!=0);
  - r_valid_i with empty FIFO.
  - Cleared only by rst_i.
- A requester may drop req_valid_i without handshake; the arbiter simply skips it.
- Pointer wrap: rr_ptr = NUM_REQ-1 with a win returns rr_ptr to 0.
- Widths: rr_ptr and FIFO entries are $clog2(NUM_REQ) bits; count is $clog2(MAX_OUTST)+1 bits.

Test Plan:
- Arbitration: all 5 req_valid_i high, ar_ready_i=1 → req_ready_o grants 0,1,2,3 in successive cycles, then outst_full_o=1 and no grant. Return 4 R beats → rsp_valid_o one-hot in order 0,1,2,3; next grant goes to requester 4, then 0.
- Latency: single request k=2, addr 0x8000_0010, at cycle T → ar_valid_o=1 with ar_addr_o=0x8000_0010 at T+1. Addr held while ar_ready_i=0 for 3 cycles; ar_valid_o=0 the cycle after the handshake.
- Backpressure: R beat 0xDEADBEEF for requester 1 with rsp_ready_i[1]=0 for 2 cycles → r_ready_o=0 and data stable. On rsp_ready_i[1]=1 → pop, count-1.
- Simultaneous: count=MAX_OUTST with R pop and pending request in the same cycle → no accept that cycle (gated by pre-pop count); accept next cycle; count returns to MAX_OUTST.
- Errors: r_resp_i=2'b10 → data still delivered, err_o=1 sticky. R beat with empty FIFO → r_ready_o=1, no rsp_valid_o, err_o=1.
- Reset mid-op: rst_i high with 3 in flight → next cycle ar_valid_o=0, idle_o=1, err_o=0, rr_ptr=0 (first grant to requester 0).
